// File: rtl/player_physics_if.sv
// Tile-map collision probe bus: the physics engine drives a screen coordinate,
// the tile map answers with that pixel's solid bit in the same cycle.
interface player_physics_if;
    logic [9:0] probe_x;
    logic [9:0] probe_y;
    logic       probe_solid;

    modport master (output probe_x, output probe_y, input probe_solid);
    modport slave  (input probe_x, input probe_y, output probe_solid);
endinterface

// File: rtl/player_physics.sv
// Per-frame platformer player update: horizontal move with 4-corner collision
// probe, then gravity/jump vertical move with a second 4-corner probe.
module player_physics #(
    parameter int GRID_SIZE = 32,
    parameter int PLAYER_W  = 16,
    parameter int PLAYER_H  = 16,
    parameter int SPEED     = 2,
    parameter int GRAVITY   = 1,
    parameter int JUMP_V    = 12,
    parameter int VMAX      = 8,
    parameter int START_X   = 175,
    parameter int START_Y   = 66
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_jump,
    player_physics_if.master       tile,
    output logic [9:0]             pos_x,
    output logic [9:0]             pos_y,
    output logic [5:0]             vel_y,
    output logic                   on_ground,
    output logic                   busy,
    output logic                   done
);

    if (GRID_SIZE <= 0) begin : g_bad_grid
        $error("GRID_SIZE must be positive");
    end

    typedef enum logic [2:0] {IDLE, PX, XC, PY, YC} state_t;

    state_t             state_q;
    logic [9:0]         pos_x_q, pos_y_q, cand_x_q, cand_y_q;
    logic [9:0]         probe_x_q, probe_y_q;
    logic signed [5:0]  vel_q;
    logic               ground_q, busy_q, done_q, hit_q, jump_q;
    logic [1:0]         corner_q;

    logic [9:0]         dx, cand_x_d, commit_x, cand_y_d;
    logic signed [7:0]  vel_inc;
    logic signed [5:0]  vel_d;
    logic               last_corner;

    // Corner 0..3: top-left, top-right, bottom-left, bottom-right.
    function automatic logic [19:0] corner(input logic [9:0] bx, input logic [9:0] by,
                                           input logic [1:0] idx);
        logic [9:0] x, y;
        x = bx + (idx[0] ? 10'(PLAYER_W - 1) : 10'd0);
        y = by + (idx[1] ? 10'(PLAYER_H - 1) : 10'd0);
        return {x, y};
    endfunction

    always_comb begin
        dx = 10'd0;
        if (btn_right && !btn_left)
            dx = 10'(SPEED);
        else if (btn_left && !btn_right)
            dx = 10'(-SPEED);
        cand_x_d    = pos_x_q + dx;
        commit_x    = hit_q ? pos_x_q : cand_x_q;
        vel_inc     = {{2{vel_q[5]}}, vel_q} + 8'(GRAVITY);
        vel_d       = (vel_inc > $signed(8'(VMAX))) ? 6'(VMAX) : vel_inc[5:0];
        if (ground_q && jump_q)
            vel_d = 6'(-JUMP_V);
        cand_y_d    = pos_y_q + {{4{vel_d[5]}}, vel_d};
        last_corner = (corner_q == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pos_x_q   <= 10'(START_X);
            pos_y_q   <= 10'(START_Y);
            cand_x_q  <= 10'(START_X);
            cand_y_q  <= 10'(START_Y);
            probe_x_q <= 10'(START_X);
            probe_y_q <= 10'(START_Y);
            vel_q     <= '0;
            ground_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            jump_q    <= 1'b0;
            corner_q  <= 2'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (frame_tick) begin
                    jump_q                 <= btn_jump;
                    cand_x_q               <= cand_x_d;
                    {probe_x_q, probe_y_q} <= corner(cand_x_d, pos_y_q, 2'd0);
                    hit_q                  <= 1'b0;
                    corner_q               <= 2'd0;
                    busy_q                 <= 1'b1;
                    state_q                <= PX;
                end
                PX: begin
                    hit_q    <= hit_q | tile.probe_solid;
                    corner_q <= corner_q + 2'd1;
                    if (last_corner)
                        state_q <= XC;
                    else
                        {probe_x_q, probe_y_q} <= corner(cand_x_q, pos_y_q, corner_q + 2'd1);
                end
                XC: begin
                    pos_x_q                <= commit_x;
                    vel_q                  <= vel_d;
                    cand_y_q               <= cand_y_d;
                    {probe_x_q, probe_y_q} <= corner(commit_x, cand_y_d, 2'd0);
                    hit_q                  <= 1'b0;
                    state_q                <= PY;
                end
                PY: begin
                    hit_q    <= hit_q | tile.probe_solid;
                    corner_q <= corner_q + 2'd1;
                    if (last_corner) begin
                        done_q  <= 1'b1;
                        state_q <= YC;
                    end else begin
                        {probe_x_q, probe_y_q} <= corner(pos_x_q, cand_y_q, corner_q + 2'd1);
                    end
                end
                YC: begin
                    // Only a blocked downward move counts as landing; a ceiling bump does not.
                    if (hit_q) begin
                        vel_q    <= '0;
                        ground_q <= (vel_q > 6'sd0);
                    end else begin
                        pos_y_q  <= cand_y_q;
                        ground_q <= 1'b0;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tile.probe_x = probe_x_q;
    assign tile.probe_y = probe_y_q;
    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign vel_y        = vel_q;
    assign on_ground    = ground_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_player_physics.sv
// Bench for player_physics: directed vector table, abort sequences and random
// frames over a random tile map checked against a frame-level reference model.
module tb_player_physics;
    localparam int PW = 16, PH = 16, SPEED = 2, GRAV = 1, JV = 12, VMAX = 8;

    logic clk = 0, rst = 0, frame_tick = 0, btn_left = 0, btn_right = 0, btn_jump = 0;
    logic [9:0] pos_x, pos_y;
    logic [5:0] vel_y;
    logic on_ground, busy, done;

    player_physics_if tile();

    player_physics dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .tile(tile.master),
        .pos_x(pos_x), .pos_y(pos_y), .vel_y(vel_y),
        .on_ground(on_ground), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // mode 0: tile map, 1: never solid, 2: solid only in X-probe cycles, 3: only in Y-probe cycles
    int  mode = 1;
    int  cyc  = 0;
    bit  tiles [32][32];
    int  checks = 0, errors = 0;
    int  m_x, m_y, m_v;
    bit  m_g;

    function automatic bit map_solid(input int x, input int y);
        return tiles[(x & 1023) >> 5][(y & 1023) >> 5];
    endfunction

    always_comb begin
        case (mode)
            0: tile.probe_solid = map_solid(int'(tile.probe_x), int'(tile.probe_y));
            2: tile.probe_solid = (cyc >= 1 && cyc <= 4);
            3: tile.probe_solid = (cyc >= 6 && cyc <= 9);
            default: tile.probe_solid = 1'b0;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bit box_hit(input int bx, input int by, input int md, input bit yphase);
        if (md == 1) return 0;
        if (md == 2) return !yphase;
        if (md == 3) return yphase;
        return map_solid(bx, by) | map_solid(bx + PW - 1, by) |
               map_solid(bx, by + PH - 1) | map_solid(bx + PW - 1, by + PH - 1);
    endfunction

    task automatic model_reset();
        m_x = 175; m_y = 66; m_v = 0; m_g = 0;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit j, input int md);
        int dx, cx, v, cy;
        dx = (r && !l) ? SPEED : (l && !r) ? -SPEED : 0;
        cx = (m_x + dx) & 1023;
        if (!box_hit(cx, m_y, md, 0)) m_x = cx;
        v  = (m_g && j) ? -JV : ((m_v + GRAV > VMAX) ? VMAX : m_v + GRAV);
        cy = (m_y + v) & 1023;
        if (!box_hit(m_x, cy, md, 1)) begin
            m_y = cy; m_v = v; m_g = 0;
        end else begin
            m_v = 0; m_g = (v > 0);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after busy falls.
    task automatic do_frame(input bit l, input bit r, input bit j, input int md, input string tag);
        bit ok = 1;
        btn_left = l; btn_right = r; btn_jump = j; mode = md;
        frame_tick = 1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            cyc = k;
            if (k == 1) frame_tick = 0;
            if (busy !== (k <= 10) || done !== (k == 10)) ok = 0;
        end
        cyc = 0;
        chk({tag, "_timing"}, int'(ok), 1);
    endtask

    task automatic chk_state(input string tag, input int x, input int y, input int v, input bit g);
        chk({tag, "_pos_x"}, int'(pos_x), x);
        chk({tag, "_pos_y"}, int'(pos_y), y);
        chk({tag, "_vel_y"}, int'($signed(vel_y)), v);
        chk({tag, "_on_ground"}, int'(on_ground), int'(g));
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk); @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    typedef struct { bit l, r, j; int md; int x, y, v; bit g; } vec_t;
    vec_t tbl [10];

    initial begin
        bit seen_bad;
        int dcount;
        tbl[0] = '{0, 0, 0, 1, 175, 67,   1, 0};
        tbl[1] = '{0, 0, 0, 1, 175, 69,   2, 0};
        tbl[2] = '{0, 0, 0, 1, 175, 72,   3, 0};
        tbl[3] = '{0, 1, 0, 2, 175, 76,   4, 0};
        tbl[4] = '{0, 0, 0, 3, 175, 76,   0, 1};
        tbl[5] = '{0, 0, 1, 1, 175, 64, -12, 0};
        tbl[6] = '{1, 0, 0, 1, 173, 53, -11, 0};
        tbl[7] = '{1, 1, 0, 1, 173, 43, -10, 0};
        tbl[8] = '{0, 0, 0, 3, 173, 43,   0, 0};
        tbl[9] = '{0, 0, 1, 1, 173, 44,   1, 0};

        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                tiles[x][y] = (y >= 7) || (x == 0) || (x >= 14) || ($urandom_range(0, 9) == 0);
        tiles[5][2] = 0;

        @(negedge clk);
        do_reset();
        chk_state("reset", 175, 66, 0, 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_probe_x", int'(tile.probe_x), 175);
        chk("reset_probe_y", int'(tile.probe_y), 66);

        for (int i = 0; i < 10; i++) begin
            do_frame(tbl[i].l, tbl[i].r, tbl[i].j, tbl[i].md, $sformatf("vec%0d", i));
            chk_state($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].g);
        end

        // Probe coordinates hold in idle: last Y-probe corner of vec9 is (173+15, 44+15).
        repeat (3) @(negedge clk);
        chk("idle_probe_x", int'(tile.probe_x), 188);
        chk("idle_probe_y", int'(tile.probe_y), 59);

        // Second tick two cycles into an update is dropped.
        do_reset();
        mode = 1; btn_left = 0; btn_right = 0; btn_jump = 0;
        frame_tick = 1; seen_bad = 0; dcount = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            frame_tick = (k == 2);
            if (done) dcount++;
            if (busy !== (k <= 10) || done !== (k == 10)) seen_bad = 1;
        end
        model_frame(0, 0, 0, 1);
        chk("ignore_tick_done_pulses", dcount, 1);
        chk("ignore_tick_timing", int'(seen_bad), 0);
        chk_state("ignore_tick", m_x, m_y, m_v, m_g);

        // Reset three cycles into the X probe aborts without a done pulse.
        btn_right = 1; frame_tick = 1; seen_bad = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            frame_tick = 0;
            rst = (k == 3);
            if (k == 4) begin
                chk_state("abort", 175, 66, 0, 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_probe_x", int'(tile.probe_x), 175);
                chk("abort_probe_y", int'(tile.probe_y), 66);
            end
            if (k > 4 && (busy || done)) seen_bad = 1;
        end
        btn_right = 0;
        chk("abort_no_done", int'(seen_bad), 0);

        // Random frames over the random tile map.
        model_reset();
        for (int i = 0; i < 200; i++) begin
            bit l, r, j;
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 3) == 0);
            do_frame(l, r, j, 0, $sformatf("rnd%0d", i));
            model_frame(l, r, j, 0);
            chk_state($sformatf("rnd%0d", i), m_x, m_y, m_v, m_g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/player_physics.md
PLAYER_PHYSICS -- requirements
Module: player_physics

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 32, tile edge in pixels (informational; collision uses the tile map's solid bit only).
REQ-002 SHALL have parameter PLAYER_W, default 16, player hitbox width in pixels.
REQ-003 SHALL have parameter PLAYER_H, default 16, player hitbox height in pixels.
REQ-004 SHALL have parameter SPEED, default 2, horizontal pixels per frame.
REQ-005 SHALL have parameter GRAVITY, default 1, added to vel_y each frame.
REQ-006 SHALL have parameter JUMP_V, default 12, magnitude of jump velocity.
REQ-007 SHALL have parameter VMAX, default 8, maximum downward vel_y.
REQ-008 SHALL have parameter START_X, default 175, reset x position.
REQ-009 SHALL have parameter START_Y, default 66, reset y position.
REQ-010 SHALL have port clk, input, 1, system clock.
REQ-011 SHALL have port rst, input, 1, reset: one clock, synchronous, active-high.
REQ-012 SHALL have port frame_tick, input, 1, one-cycle pulse once per video frame.
REQ-013 SHALL have ports btn_left, btn_right and btn_jump, each input, 1, level-sensitive controls.
REQ-014 SHALL have ports probe_x and probe_y, each output, 10, registered screen coordinates driven to the tile map collision port.
REQ-015 SHALL have port probe_solid, input, 1, tile map collision data for the current probe_x/probe_y, valid in the same cycle.
REQ-016 SHALL have ports pos_x and pos_y, each output, 10, committed hitbox top-left position in screen coordinates.
REQ-017 SHALL have port vel_y, output, 6, signed two's-complement vertical velocity; positive is down.
REQ-018 SHALL have ports on_ground, busy and done, each output, 1: grounded flag, update in progress, and a one-cycle pulse on update completion.

Function
REQ-019 SHALL implement the states IDLE, PX, XC, PY, YC.
REQ-020 In IDLE with frame_tick=1, SHALL, at that edge, do all of the following: latch buttons; set cand_x = pos_x + dx; load the corner-0 probe; enter PX; assert busy.
- dx = +SPEED when only btn_right is high.
- dx = -SPEED when only btn_left is high.
- dx = 0 otherwise, including both buttons high.
REQ-021 Corners SHALL be probed in the order (cx,cy), (cx+PLAYER_W-1,cy), (cx,cy+PLAYER_H-1), (cx+PLAYER_W-1,cy+PLAYER_H-1), with one corner per cycle.
REQ-022 PX SHALL last 4 cycles, and probe_solid SHALL be OR-ed into a hit flag, sampled at the end of each cycle.
REQ-023 XC SHALL last 1 cycle, and SHALL set pos_x = cand_x if no hit, otherwise leave pos_x unchanged.
REQ-024 XC SHALL compute the new vel_y as follows, then set cand_y = pos_y + sign-extended vel_y using the committed pos_x:
- vel_y = -JUMP_V if on_ground and the latched jump bit are both set.
- vel_y = min(vel_y + GRAVITY, VMAX) otherwise.
REQ-025 PY SHALL last 4 cycles and probe at (pos_x, cand_y), using the same order as PX.
REQ-026 YC SHALL apply the vertical result:
- No hit: pos_y = cand_y, on_ground = 0.
- Hit: pos_y unchanged, vel_y = 0, on_ground = 1 if the attempted vel_y > 0, else 0.
REQ-027 YC SHALL pulse done for one cycle, deassert busy and return to IDLE.
REQ-028 Latency SHALL be fixed: done is high in the 10th cycle after the frame_tick edge, and busy is high for exactly 10 cycles.
REQ-029 frame_tick received while busy=1 SHALL be ignored and not queued.
REQ-030 All coordinate arithmetic SHALL be 10-bit modulo 1024; out-of-map coordinates rely on the tile map reporting them solid.
REQ-031 probe_x/probe_y SHALL hold their last value in IDLE.

Reset
REQ-032 On rst=1 at a clock edge, in any state including mid-update, SHALL apply:
- state IDLE.
- pos_x = START_X, pos_y = START_Y.
- vel_y = 0, on_ground = 0.
- busy = 0, done = 0, hit flag cleared.
- probe_x = START_X, probe_y = START_Y.
REQ-033 rst SHALL take priority over frame_tick in the same cycle.

Verification
REQ-034 Reset: assert rst -> pos=(175,66), vel_y=0, on_ground=0, busy=0, done=0.
REQ-035 Free fall: probe_solid=0, no buttons, 3 ticks -> vel_y 1,2,3; pos_y 67,69,72; done 10 cycles after each tick.
REQ-036 Landing: pos_y=66, vel_y=3, probe_solid=1 only during PY -> pos_y=66, vel_y=0, on_ground=1.
REQ-037 Wall: btn_right, pos_x=175, probe_solid=1 only during PX -> pos_x=175, and pos_y advances by the new vel_y.
REQ-038 Jump: on_ground=1, btn_jump, probe_solid=0 -> vel_y=-12 (6'b110100), pos_y decreases by 12, on_ground=0.
REQ-039 Abort: a second tick 2 cycles after the first is ignored; rst 3 cycles into PX -> IDLE with reset values next cycle and no done pulse.
